// File: rtl/jtkcpu_intctl_if.sv
// CPU-side bus into the jtkcpu interrupt/sim-control block.
//   cs   : block select from the address decoder
//   we   : CPU write strobe
//   addr : register select (0 CTRL, 1 DLY, 2 STATUS, 3 CNT)
//   din  : CPU write data
//   dout : read data, combinational from addr
interface jtkcpu_intctl_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs, we, addr, din, input  dout);
  modport slave  (input  cs, we, addr, din, output dout);
endinterface

// File: rtl/jtkcpu_intctl.sv
// Interrupt and simulation-control sequencer feeding the jtkcpu interrupt pins.
// A CTRL write latches the nmi/firq/irq requests and starts a delay of dly+1
// cen2 ticks; when it expires, every requested line asserts. Clearing a
// request drops its line on the next tick. Also latches the pass flag and
// produces a sticky finish flag FINISH_DLY ticks after a finish request.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   cen2                   : clock enable; state only moves on cen2 edges
//   bus                    : CPU register interface (slave side)
//   nmi_n, firq_n, irq_n   : active-low interrupt lines to the CPU
//   good                   : latched pass flag
//   finish                 : sticky end-of-simulation flag
module jtkcpu_intctl #(
  parameter int FINISH_DLY = 20,
  parameter int CW         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen2,
  jtkcpu_intctl_if.slave     bus,
  output logic               nmi_n,
  output logic               firq_n,
  output logic               irq_n,
  output logic               good,
  output logic               finish
);
  localparam int FW = (FINISH_DLY < 2) ? 1 : $clog2(FINISH_DLY + 1);

  typedef enum logic { S_IDLE, S_WAIT } state_t;

  // bit 2 = nmi, bit 1 = firq, bit 0 = irq (matches din[7:5])
  logic [2:0]    req_q, req_d, line_q, line_d;
  logic [CW-1:0] dly_q, dly_d, cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic          good_q, good_d, finish_q, finish_d;
  logic          farm_q, farm_d;   // finish countdown in progress
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          wr, wr_ctrl, wr_dly, fire;

  assign wr      = cen2 & bus.cs & bus.we;
  assign wr_ctrl = wr & (bus.addr == 2'd0);
  assign wr_dly  = wr & (bus.addr == 2'd1);

  always_comb begin
    req_d    = req_q;
    line_d   = line_q;
    dly_d    = dly_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    good_d   = good_q;
    finish_d = finish_q;
    farm_d   = farm_q;
    fcnt_d   = fcnt_q;
    fire     = 1'b0;
    if (cen2) begin
      // A CTRL write restarts the delay and suppresses a fire on the same edge.
      if (wr_ctrl) begin
        cnt_d   = dly_q;
        state_d = S_WAIT;
      end else if (state_q == S_WAIT) begin
        if (cnt_q == '0) begin
          fire    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      // Old req is used: clears take effect one tick after the write, and a
      // newly set request has to wait for the next fire.
      line_d = req_q & (line_q | {3{fire}});
      if (wr_ctrl) begin
        req_d  = bus.din[7:5];
        good_d = bus.din[1];
      end
      if (wr_dly) dly_d = bus.din[CW-1:0];
      // Finishing on the fcnt<=1 tick also covers FINISH_DLY of 0 and 1.
      if (wr_ctrl && bus.din[0]) begin
        fcnt_d = FW'(FINISH_DLY);
        farm_d = 1'b1;
      end else if (farm_q) begin
        if (fcnt_q <= FW'(1)) begin
          finish_d = 1'b1;
          farm_d   = 1'b0;
          fcnt_d   = '0;
        end else begin
          fcnt_d = fcnt_q - FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= '0;
      line_q   <= '0;
      dly_q    <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      good_q   <= 1'b0;
      finish_q <= 1'b0;
      farm_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      req_q    <= req_d;
      line_q   <= line_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      good_q   <= good_d;
      finish_q <= finish_d;
      farm_q   <= farm_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    case (bus.addr)
      2'd0:    bus.dout = {req_q, 3'b000, good_q, finish_q};
      2'd1:    bus.dout = 8'(dly_q);
      2'd2:    bus.dout = {line_q, state_q == S_WAIT, 4'b0000};
      default: bus.dout = 8'(cnt_q);
    endcase
  end

  assign nmi_n  = ~line_q[2];
  assign firq_n = ~line_q[1];
  assign irq_n  = ~line_q[0];
  assign good   = good_q;
  assign finish = finish_q;
endmodule

// File: tb/tb_jtkcpu_intctl.sv
module tb_jtkcpu_intctl;
  localparam int FD = 20;

  logic clk = 1'b0, rst = 1'b1, cen2 = 1'b0;
  logic nmi_n, firq_n, irq_n, good, finish;
  int   n_pass = 0, n_tot = 0;

  jtkcpu_intctl_if bus();

  jtkcpu_intctl #(.FINISH_DLY(FD), .CW(8)) dut (
    .clk(clk), .rst(rst), .cen2(cen2), .bus(bus),
    .nmi_n(nmi_n), .firq_n(firq_n), .irq_n(irq_n),
    .good(good), .finish(finish)
  );

  always #10 clk = ~clk;

  // Reference model: delay tracked as "ticks until fire", finish as
  // "ticks until finish"; lines as a plain 3-bit set.
  logic [2:0] m_req, m_line;
  int         m_dly, m_tf, m_fl;
  bit         m_good, m_fin;

  task automatic mreset();
    m_req = 0; m_line = 0; m_dly = 0; m_tf = 0; m_fl = 0; m_good = 0; m_fin = 0;
  endtask

  task automatic step(input bit cen, input bit cs, input bit we,
                      input logic [1:0] a, input logic [7:0] d);
    bit wc, wd, fire;
    @(negedge clk);
    cen2 = cen; bus.cs = cs; bus.we = we; bus.addr = a; bus.din = d;
    @(posedge clk);
    if (cen && !rst) begin
      wc = cs && we && a == 2'd0;
      wd = cs && we && a == 2'd1;
      fire = !wc && m_tf == 1;
      m_line = m_req & (m_line | {3{fire}});
      if (wc) m_tf = m_dly + 1; else if (m_tf > 0) m_tf--;
      if (wc) begin m_req = d[7:5]; m_good = d[1]; end
      if (wd) m_dly = d;
      if (wc && d[0]) m_fl = (FD == 0) ? 1 : FD;
      else if (m_fl > 0) begin m_fl--; if (m_fl == 0) m_fin = 1; end
    end
    #1;
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.addr = a;
    #1;
    d = bus.dout;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    bus.cs = 0; bus.we = 0; bus.addr = 0; bus.din = 0;
    mreset();
    #25;
    n_tot++; if ({nmi_n, firq_n, irq_n} !== 3'b111) $display("FAIL reset_lines: got %b exp 111", {nmi_n, firq_n, irq_n}); else n_pass++;
    n_tot++; if ({good, finish} !== 2'b00) $display("FAIL reset_flags: got %b exp 00", {good, finish}); else n_pass++;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_tot++; if (v !== 8'h00) $display("FAIL reset_read%0d: got %02h exp 00", a, v); else n_pass++;
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_delayed_irq();
    logic [7:0] v;
    wr(2'd1, 8'd5);
    wr(2'd0, 8'h20);
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_tot++; if (irq_n !== (k == 6 ? 1'b0 : 1'b1)) $display("FAIL dirq_irq_n t%0d: got %b exp %b", k, irq_n, k != 6); else n_pass++;
      n_tot++; if ({nmi_n, firq_n} !== 2'b11) $display("FAIL dirq_other t%0d: got %b exp 11", k, {nmi_n, firq_n}); else n_pass++;
      rd(2'd2, v);
      n_tot++; if (v[4] !== (k < 6)) $display("FAIL dirq_busy t%0d: got %b exp %b", k, v[4], k < 6); else n_pass++;
    end
  endtask

  task automatic test_clear();
    logic [7:0] v;
    wr(2'd0, 8'h00);
    n_tot++; if (irq_n !== 1'b0) $display("FAIL clr_write_edge: got %b exp 0", irq_n); else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tot++; if (irq_n !== 1'b1) $display("FAIL clr_irq_n t%0d: got %b exp 1", k, irq_n); else n_pass++;
      rd(2'd2, v);
      n_tot++; if (v[4] !== (k < 6)) $display("FAIL clr_busy t%0d: got %b exp %b", k, v[4], k < 6); else n_pass++;
    end
  endtask

  task automatic test_reload();
    wr(2'd1, 8'd10);
    wr(2'd0, 8'h40);
    repeat (4) tick();
    wr(2'd0, 8'hC0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_tot++; if ({nmi_n, firq_n} !== (k == 11 ? 2'b00 : 2'b11))
        $display("FAIL reload t%0d: got %b exp %b", k, {nmi_n, firq_n}, (k == 11 ? 2'b00 : 2'b11)); else n_pass++;
    end
  endtask

  task automatic test_max_dly();
    logic [7:0] v;
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'h20);
    rd(2'd3, v);
    n_tot++; if (v !== 8'hFF) $display("FAIL maxdly_cnt: got %02h exp ff", v); else n_pass++;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k >= 254) begin
        n_tot++; if (irq_n !== (k == 256 ? 1'b0 : 1'b1)) $display("FAIL maxdly t%0d: got %b exp %b", k, irq_n, k != 256); else n_pass++;
      end
    end
    rd(2'd3, v);
    n_tot++; if (v !== 8'h00) $display("FAIL maxdly_nowrap: got %02h exp 00", v); else n_pass++;
  endtask

  task automatic test_finish();
    logic [7:0] v;
    wr(2'd0, 8'h03);
    n_tot++; if (good !== 1'b1) $display("FAIL fin_good: got %b exp 1", good); else n_pass++;
    for (int c = 1; c <= 30; c++) begin
      step((c >= 8 && c <= 14) ? 1'b0 : 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
      n_tot++; if (finish !== (c >= 27)) $display("FAIL fin_clk%0d: got %b exp %b", c, finish, c >= 27); else n_pass++;
    end
    rd(2'd0, v);
    n_tot++; if (v[1:0] !== 2'b11) $display("FAIL fin_read: got %b exp 11", v[1:0]); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    wr(2'd1, 8'd0);
    wr(2'd0, 8'hE0);
    tick();
    n_tot++; if ({nmi_n, firq_n, irq_n} !== 3'b000) $display("FAIL ar_arm: got %b exp 000", {nmi_n, firq_n, irq_n}); else n_pass++;
    wr(2'd1, 8'd50);
    wr(2'd0, 8'hE0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_tot++; if ({nmi_n, firq_n, irq_n} !== 3'b000) $display("FAIL ar_hold t%0d: got %b exp 000", k, {nmi_n, firq_n, irq_n}); else n_pass++;
    end
    #4 rst = 1;
    #1;
    n_tot++; if ({nmi_n, firq_n, irq_n} !== 3'b111) $display("FAIL ar_lines: got %b exp 111", {nmi_n, firq_n, irq_n}); else n_pass++;
    rd(2'd2, v);
    n_tot++; if (v !== 8'h00) $display("FAIL ar_status: got %02h exp 00", v); else n_pass++;
    rd(2'd1, v);
    n_tot++; if (v !== 8'h00) $display("FAIL ar_dly: got %02h exp 00", v); else n_pass++;
    mreset();
    @(negedge clk); rst = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k % 10 == 0) begin
        n_tot++; if ({nmi_n, firq_n, irq_n} !== 3'b111) $display("FAIL ar_nofire t%0d: got %b exp 111", k, {nmi_n, firq_n, irq_n}); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] v, e, d;
    logic [1:0] a, ra;
    bit c, s, w;
    @(negedge clk); rst = 1; mreset();
    @(negedge clk); rst = 0;
    for (int i = 0; i < 1500; i++) begin
      c = $urandom_range(0, 3) != 0;
      s = $urandom_range(0, 1) == 1;
      w = $urandom_range(0, 4) == 0;
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (a == 2'd1 && $urandom_range(0, 7) != 0) d = 8'($urandom_range(0, 6));
      if (a == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      step(c, s, w, a, d);
      n_tot++; if ({nmi_n, firq_n, irq_n} !== ~m_line)
        $display("FAIL rnd_lines i%0d: got %b exp %b", i, {nmi_n, firq_n, irq_n}, ~m_line); else n_pass++;
      ra = 2'($urandom_range(0, 3));
      case (ra)
        2'd0: e = {m_req, 3'b000, m_good, m_fin};
        2'd1: e = 8'(m_dly);
        2'd2: e = {m_line, m_tf > 0, 4'b0000};
        default: e = 8'(m_tf > 0 ? m_tf - 1 : 0);
      endcase
      rd(ra, v);
      n_tot++; if (v !== e) $display("FAIL rnd_read%0d i%0d: got %02h exp %02h", ra, i, v, e); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_delayed_irq();
    test_clear();
    test_reload();
    test_max_dly();
    test_finish();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/jtkcpu_intctl.md
Name: jtkcpu_intctl

Overview:
Memory-mapped interrupt and simulation-control sequencer that drives the jtkcpu nmi_n/firq_n/irq_n inputs. The CPU sets interrupt requests by writing a control byte. Each request becomes active on its CPU line after a programmable number of cen2 ticks. The block also latches the pass/fail flag and produces a delayed finish strobe for the bench. It sits directly upstream of jtkcpu's interrupt pins, on the CPU data bus at the simulation-control address.

Parameters:
FINISH_DLY, 20, number of cen2 ticks from finish request to finish assertion
CW, 8, width of the delay counter and of the delay register

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
cen2  input  1  clock enable; all state updates occur only on clk edges with cen2=1
cs  input  1  block select from address decoder
we  input  1  CPU write strobe
addr  input  2  register select
din  input  8  CPU write data
dout  output  8  read data, combinational from addr
nmi_n  output  1  NMI to CPU, active-low
firq_n  output  1  FIRQ to CPU, active-low
irq_n  output  1  IRQ to CPU, active-low
good  output  1  latched pass flag
finish  output  1  end-of-simulation flag, sticky

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values:
  - req[2:0]=0, line[2:0]=0, dly=0, cnt=0, state=IDLE, good=0, finish=0, fcnt idle.
  - nmi_n=firq_n=irq_n=1. dout reflects the reset registers.
  - Asserting rst mid-operation returns everything to these values immediately.
- Register map. A write is a clk edge with cen2&cs&we.
  - addr 0, write CTRL:
    - {req_nmi,req_firq,req_irq}<=din[7:5]
    - good<=din[1]
    - if din[0]: fcnt<=FINISH_DLY (restarts if already counting)
    - cnt<=dly, state<=WAIT
  - addr 1, write DLY: dly<=din[CW-1:0].
  - addr 0, read: {req[2:0],3'b0,good,finish}.
  - addr 1, read: dly.
  - addr 2, read: {line_nmi,line_firq,line_irq,busy,4'b0}, where busy = (state==WAIT).
  - addr 3, read: cnt.
  - addr 2 and 3 are read-only; writes to them are ignored.
- State machine, advancing on cen2 only:
  - IDLE: no action.
  - WAIT: if cnt==0 then fire=1 (combinational), state<=IDLE; else cnt<=cnt-1.
  - A CTRL write in any state reloads cnt and enters WAIT. The write has priority: fire is forced to 0 on that edge.
- Line update, on each cen2 edge: line[i] <= req[i] & (line[i] | fire).
  - The update uses req as it was before any same-edge write.
  - Outputs: nmi_n=~line_nmi, firq_n=~line_firq, irq_n=~line_irq.
- Latency:
  - A CTRL write on cen2 edge E0 that sets a request asserts the line on edge E(dly+1). dly=0 gives 1 tick.
  - A CTRL write on E0 that clears a request deasserts the line on E1. No delay is applied to clearing.
  - An already-active line whose request stays set stays asserted across later CTRL writes.
  - A newly set bit waits for the next fire.
- Arithmetic: cnt is unsigned CW bits and never decrements below 0, so there is no wrap. dly=2^CW-1 gives 2^CW ticks.
- Finish counter:
  - fcnt decrements on cen2 while >0.
  - On the tick it transitions 1->0, finish<=1. finish stays 1 until reset.
  - With FINISH_DLY=0, finish sets on the edge after the write.
- cen2=0 freezes all state. CPU writes on non-cen2 edges are ignored.

Test Plan:
- Reset check: reset, then read all four addresses -> nmi_n/firq_n/irq_n=1, finish=0, good=0; reads return 00,00,00,00.
- Delayed IRQ: write DLY=5, then CTRL=0x20 -> irq_n falls exactly on the 6th cen2 edge after the write; busy=1 until then; firq_n and nmi_n stay 1.
- Immediate clear: with IRQ active, write CTRL=0x00 -> irq_n=1 on the next cen2 edge; busy stays 1 for dly+1 ticks; irq_n stays high after the fire.
- Reload: DLY=10, write CTRL=0x40, then 4 ticks later write CTRL=0xC0 -> both firq_n and nmi_n fall 11 ticks after the second write, none earlier.
- Finish and pass: write CTRL=0x03 -> good=1 next edge; finish=1 after exactly 20 cen2 ticks and stays set; with cen2 gated low for 7 clocks mid-count, finish is delayed by those 7 clocks.
- Async reset mid-WAIT: DLY=50, CTRL=0xE0, assert rst at tick 10 -> all lines high immediately; no fire after rst releases.
